lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store sequencer for the memory stage of the pipelined RV32I core. It takes the memory-stage instruction's operation, address and store data, and runs one transaction at a time on a single-outstanding req/ack data bus. It stalls the pipeline while the transaction is in flight and returns the formatted load result that writeback selects as the memory source. It also detects misaligned accesses, bus errors and bus timeouts, and discards in-flight transactions that are flushed.

## Interface
- TIMEOUT, 255: maximum cycles in BUSY/DRAIN without bus_ack before the access is aborted (≥1).
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- mem_valid  in  1  memory-stage instruction valid.
- mem_op  in  2  operation: 0 = none, 1 = load, 2 = store, 3 = none.
- mem_funct3  in  3  RV32I funct3 of the load/store.
- mem_addr  in  32  effective byte address.
- mem_wdata  in  32  store data (rs2).
- flush  in  1  kill the current memory-stage instruction.
- stall  out  1  hold the pipeline (combinational from state and inputs).
- bus_req  out  1  transaction request (registered).
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {mem_addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete.
- bus_err  in  1  error; valid only with bus_ack.
- bus_rdata  in  32  read word; valid with bus_ack.
- load_valid  out  1  one-cycle pulse: load_data is valid.
- load_data  out  32  sign- or zero-extended load result.
- exc_misaligned  out  1  one-cycle pulse: misaligned access.
- exc_access  out  1  one-cycle pulse: bus error or timeout.

## Operation
- States: IDLE, BUSY, DRAIN, DONE.
- Request: mem_valid & (mem_op == 1 or 2) & !flush, sampled in IDLE.
- Size decode:
  - Byte: funct3 0/4 (load) or 0 (store).
  - Half: funct3 1/5 (load) or 1 (store).
  - Word: all other funct3 values.
  - Loads with funct3 4/5 zero-extend; all other loads sign-extend.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] ≠ 0.

IDLE
- Misaligned request: pulse exc_misaligned next cycle and stay in IDLE. No bus activity and no stall.
- Aligned request: register the bus outputs, set bus_req = 1, load the timeout counter with 0, and go to BUSY.
  - Byte: be = 1 << addr[1:0], wdata = {4{d[7:0]}}.
  - Half: be = 3 << addr[1:0], wdata = {2{d[15:0]}}.
  - Word: be = 4'hF, wdata = d.
  - Loads: bus_we = 0 and bus_wdata = 0. bus_be is set for loads exactly as for stores.

BUSY
- On bus_ack:
  - Drop bus_req and go to DONE.
  - For a load without bus_err, register load_data = extend(bus_rdata >> (8 × addr[1:0])) with the size and sign captured at issue.
  - If bus_err is set, record an error instead.
- flush without ack: go to DRAIN, keeping bus_req high.
- flush together with ack: the ack wins, but the result is discarded. Go to IDLE with no pulses.
- Timeout counter reaching TIMEOUT: drop bus_req, go to DONE, and record an error.

DRAIN
- Hold bus_req until bus_ack or timeout, then go to IDLE.
- No load_valid and no exceptions are produced.

DONE (one cycle)
- Pulse load_valid (load, no error) or exc_access (error or timeout).
- A store without error produces no pulse.
- Return to IDLE. The pipeline advances at the end of this cycle.

Stall
- stall = BUSY | DRAIN | (IDLE & aligned request). DONE does not stall.
- stall is forced to 0 during reset.

Reset
- State returns to IDLE and the counter clears.
- All registered outputs reset to 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_valid, load_data, exc_misaligned, exc_access.
- Reset mid-transaction drops bus_req immediately. The bus must tolerate an abandoned request.

## Timing
- Minimum load, with request at cycle 0 and ack at cycle 1:
  - Cycle 0: stall = 1.
  - Cycle 1: bus_req = 1.
  - Cycle 2: DONE, load_valid = 1, stall = 0.
- Occupancy is 3 cycles minimum; each extra ack wait adds 1.
- bus_addr, bus_we, bus_be and bus_wdata are stable from bus_req rise until the ack cycle.
- bus_req falls the cycle after ack or timeout.
- Timeout fires when the counter reaches TIMEOUT with no ack.
  - bus_req is high for TIMEOUT + 1 cycles.
  - exc_access follows one cycle later.
- exc_misaligned appears 1 cycle after the request and is never accompanied by stall.
- load_data holds its value until the next successful load.

## Test plan
- LB at address 0x103, bus_rdata 0x80FF_1234, ack 1 cycle after bus_req:
  - bus_addr = 0x100, bus_be = 4'b1000, load_data = 0xFFFF_FF80.
  - load_valid is high exactly at cycle 2, and stall is high for cycles 0–1.
- SH at address 0x202 with data 0x0000_ABCD, ack after 3 wait cycles:
  - bus_we = 1, bus_be = 4'b1100, bus_wdata = 0xABCD_ABCD.
  - stall is high for 5 cycles; no load_valid and no exc pulses.
- LW at address 0x0000_0006: exc_misaligned pulses 1 cycle later; bus_req and stall stay at 0.
- LHU at 0x10, bus_ack with bus_err: exc_access pulses in DONE, load_valid stays 0, and load_data keeps its previous value.
- TIMEOUT = 4, no ack: bus_req is high for 5 cycles, exc_access pulses once, stall then drops, and the FSM returns to IDLE.
- Load issued, flush 1 cycle after bus_req, ack 2 cycles later:
  - bus_req stays high until the ack.
  - No load_valid and no exc pulses.
  - The next request is accepted the cycle after returning to IDLE.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store sequencer for the RV32I memory stage
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid_i,
    input  logic [1:0]  mem_op_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic        exc_misaligned_o,
    output logic        exc_access_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]    be_q, be_d;
    logic          lv_q, lv_d, mis_q, mis_d, acc_q, acc_d;
    logic          load_q, load_d, byte_q, byte_d, half_q, half_d, uns_q, uns_d;
    logic [1:0]    off_q, off_d;

    logic          is_load, is_store, request, sz_byte, sz_half, misaligned, timeout;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new, shifted, ext;

    // request decode, size/alignment and lane formatting for issue and load return
    always_comb begin
        is_load    = mem_op_i == 2'd1;
        is_store   = mem_op_i == 2'd2;
        request    = mem_valid_i & (is_load | is_store) & !flush_i;
        sz_byte    = mem_funct3_i == 3'd0 | (is_load & mem_funct3_i == 3'd4);
        sz_half    = mem_funct3_i == 3'd1 | (is_load & mem_funct3_i == 3'd5);
        misaligned = (sz_half & mem_addr_i[0]) | (!sz_byte & !sz_half & mem_addr_i[1:0] != 2'd0);
        be_new     = sz_byte ? 4'b0001 << mem_addr_i[1:0] : sz_half ? 4'b0011 << mem_addr_i[1:0] : 4'hF;
        wdata_new  = is_load ? 32'd0 : sz_byte ? {4{mem_wdata_i[7:0]}} :
                     sz_half ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
        shifted    = bus_rdata_i >> {off_q, 3'b000};
        ext        = byte_q ? {{24{!uns_q & shifted[7]}}, shifted[7:0]} :
                     half_q ? {{16{!uns_q & shifted[15]}}, shifted[15:0]} : shifted;
        timeout    = cnt_q == CW'(TIMEOUT);
        stall_o    = !reset & (state_q == BUSY | state_q == DRAIN |
                               (state_q == IDLE & request & !misaligned));
    end

    // next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        lv_d    = 1'b0;
        mis_d   = 1'b0;
        acc_d   = 1'b0;
        load_d  = load_q;
        byte_d  = byte_q;
        half_d  = half_q;
        uns_d   = uns_q;
        off_d   = off_q;
        case (state_q)
            IDLE: begin
                if (request & misaligned) begin
                    mis_d = 1'b1;
                end else if (request) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {mem_addr_i[31:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    load_d  = is_load;
                    byte_d  = sz_byte;
                    half_d  = sz_half;
                    uns_d   = is_load & mem_funct3_i[2];
                    off_d   = mem_addr_i[1:0];
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    req_d   = 1'b0;
                    state_d = flush_i ? IDLE : DONE;
                    lv_d    = !flush_i & load_q & !bus_err_i;
                    acc_d   = !flush_i & bus_err_i;
                    ld_d    = (!flush_i & load_q & !bus_err_i) ? ext : ld_q;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    state_d = flush_i ? IDLE : DONE;
                    acc_d   = !flush_i;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = flush_i ? DRAIN : BUSY;
                end
            end
            DRAIN: begin
                if (bus_ack_i | timeout) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs, synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
            acc_q   <= 1'b0;
            load_q  <= 1'b0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            uns_q   <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            lv_q    <= lv_d;
            mis_q   <= mis_d;
            acc_q   <= acc_d;
            load_q  <= load_d;
            byte_q  <= byte_d;
            half_q  <= half_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    assign bus_req_o        = req_q;
    assign bus_we_o         = we_q;
    assign bus_addr_o       = addr_q;
    assign bus_be_o         = be_q;
    assign bus_wdata_o      = wdata_q;
    assign load_valid_o     = lv_q;
    assign load_data_o      = ld_q;
    assign exc_misaligned_o = mis_q;
    assign exc_access_o     = acc_q;
endmodule
